// File: rtl/booth_seq_mac_pkg.sv
// Shared types and constants for the sequential radix-4 Booth MAC.
package booth_seq_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam int BOOTH_STEPS = 4;   // radix-4 slices of an 8-bit multiplier
  localparam int SLICE_W     = 3;   // {a[2s+1], a[2s], a[2s-1]}
  localparam int PP_W        = 10;  // signed range of {0, +-b, +-2b}
  localparam int OPD_W       = 8;   // int8 operands

endpackage

// File: rtl/booth_seq_mac_if.sv
// Operand/result handshake bundle for booth_seq_mac.
interface booth_seq_mac_if
  import booth_seq_mac_pkg::*;
#(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [OPD_W-1:0] in_a;
  logic [OPD_W-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, busy
  );
endinterface

// File: rtl/booth_partial_product_generator.sv
// Radix-4 Booth partial-product generator: maps one 3-bit multiplier slice
// to a signed partial product in {0, +-b, +-2b}. The negated multiplicand is
// supplied pre-computed (9 bits) so -(-128) = +128 needs no extra adder here.
module booth_partial_product_generator
  import booth_seq_mac_pkg::*;
(
  input  logic [SLICE_W-1:0] operand_slice_a,
  input  logic [OPD_W-1:0]   operand_b,
  input  logic [OPD_W:0]     operand_b_neg,
  output logic [PP_W-1:0]    partial_product
);

  // Booth recoding of the slice into a selected, sign-extended multiple of b
  always_comb begin
    partial_product = '0;
    case (operand_slice_a)
      3'b001, 3'b010: partial_product = {{2{operand_b[OPD_W-1]}}, operand_b};
      3'b011:         partial_product = {operand_b[OPD_W-1], operand_b, 1'b0};
      3'b100:         partial_product = {operand_b_neg, 1'b0};
      3'b101, 3'b110: partial_product = {operand_b_neg[OPD_W], operand_b_neg};
      default:        partial_product = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mac.sv
// Sequential radix-4 Booth multiply-accumulate: one int8 pair per handshake,
// four Booth slices per pair through a single partial-product generator,
// accumulated into an ACC_W-bit wrapping accumulator; emits on in_last.
module booth_seq_mac
  import booth_seq_mac_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  booth_seq_mac_if.slave  bus
);

  localparam int STEP_W = $clog2(BOOTH_STEPS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OPD_W:0]     a_sh_q, a_sh_d;
  logic [OPD_W-1:0]   b_q, b_d;
  logic [OPD_W:0]     b_neg_q, b_neg_d;
  logic               last_q, last_d;
  logic [STEP_W-1:0]  step_q, step_d;

  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   pp_shifted;

  booth_partial_product_generator u_ppg (
    .operand_slice_a (a_sh_q[SLICE_W-1:0]),
    .operand_b       (b_q),
    .operand_b_neg   (b_neg_q),
    .partial_product (pp)
  );

  // Weight of slice s is 4^s, so shift by 2*step
  assign pp_ext     = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
  assign pp_shifted = pp_ext << {step_q, 1'b0};

  // Next-state and datapath updates; everything holds by default
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_d     = b_q;
    b_neg_d = b_neg_q;
    last_d  = last_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = {bus.in_a, 1'b0};
          b_d     = bus.in_b;
          b_neg_d = '0 - {bus.in_b[OPD_W-1], bus.in_b};
          last_d  = bus.in_last;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = acc_q + pp_shifted;
        a_sh_d = {{2{a_sh_q[OPD_W]}}, a_sh_q[OPD_W:2]};
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(BOOTH_STEPS - 1))
          state_d = last_q ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight group
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_q     <= '0;
      b_neg_q <= '0;
      last_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      b_neg_q <= b_neg_d;
      last_q  <= last_d;
      step_q  <= step_d;
    end
  end

  // Status decodes from registered state, forced low while reset is held
  assign bus.in_ready  = ~rst & (state_q == S_IDLE);
  assign bus.out_valid = ~rst & (state_q == S_HOLD);
  assign bus.busy      = ~rst & (state_q != S_IDLE);
  assign bus.out_acc   = acc_q;

endmodule
